hazard_md_ctrl: RTL and testbench
=================================

Name: hazard_md_ctrl

Overview:
- Parametrised hazard unit for the 5-stage MIPS pipeline (F/D/E/M/W).
- Generalises data-hazard detection to a Tnew/Tuse comparison over a configurable register-address width.
- Generates forwarding selects for the D, E and M stages.
- Adds a multi-cycle multiply/divide busy tracker that stalls HI/LO consumers, plus a saturating stall-cycle performance counter.

Parameters:
- REG_AW, 5, register address width; address 0 is never a hazard or forward source.
- MULT_CYCLES, 5, E-stage busy cycles for mult/multu (1..255).
- DIV_CYCLES, 10, E-stage busy cycles for div/divu (1..255).
- CNT_W, 16, stall performance counter width.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- D_rs, D_rt  in  REG_AW each  source registers of the instruction in D.
- rs_tuse, rt_tuse  in  2 each  consumer stage: 0=D, 1=E, 2=M, 3=unused.
- E_rs, E_rt, M_rt  in  REG_AW each  source registers carried in E and M.
- E_wb, M_wb, W_wb  in  REG_AW each  destination registers in E, M and W.
- E_type, M_type, W_type  in  2 each  producer type: 0=none, 1=PC (link), 2=ALU, 3=DM.
- E_md_start  in  1  mult/div issuing in E this cycle.
- E_md_is_div  in  1  qualifies E_md_start: 1=div, 0=mult.
- D_md_use  in  1  instruction in D reads/writes HI/LO or is mult/div.
- cnt_clr  in  1  synchronous clear of stall_cnt.
- stall_pc, stall_D  out  1 each  hold PC and the F/D register.
- flush_E  out  1  insert a bubble into D/E.
- stall_cause  out  2  bit0 = data hazard, bit1 = MD hazard.
- fwd_D_rs, fwd_D_rt  out  3 each  0=regfile, 1=E_PC, 2=M_PC, 3=M_ALU, 4=W_result.
- fwd_E_rs, fwd_E_rt  out  2 each  0=pipe, 1=M_PC, 2=M_ALU, 3=W_result.
- fwd_M_rt  out  1  0=pipe, 1=W_result.
- md_busy  out  1  MD counter nonzero (registered).
- stall_cnt  out  CNT_W  saturating count of stall cycles.

Behaviour:
- Remaining Tnew by producer type and stage:
  - E stage: PC=0, ALU=1, DM=2.
  - M stage: PC=0, ALU=0, DM=1.
  - W stage: 0.
  - Type none: never a producer.
- Data stall rule:
  - data_stall = OR over {rs, rt} and over {E, M} of: src==wb AND wb!=0 AND type!=none AND Tnew > Tuse.
  - Tuse=3 never stalls.
- Forwarding priority: youngest producer wins.
  - D selects, in priority order: E PC, then M PC/M ALU, then W (any type).
  - E selects use E_rs/E_rt against M then W.
  - M select uses M_rt against W.
  - A producer whose value is not yet ready is never selected; a stall covers that case.
- MD tracker:
  - 8-bit down-counter md_cnt.
  - When E_md_start=1, load MULT_CYCLES or DIV_CYCLES (start takes priority, including when already busy: reload).
  - Otherwise decrement while nonzero.
  - md_busy = (md_cnt != 0); it rises the cycle after start.
  - md_stall = D_md_use AND (md_busy OR E_md_start).
- Stall outputs:
  - stall = data_stall OR md_stall.
  - stall_pc = stall_D = flush_E = stall (combinational).
  - stall_cause = {md_stall, data_stall}.
- Performance counter:
  - stall_cnt increments on each clk edge where stall=1.
  - Saturates at all-ones.
  - cnt_clr has priority over increment.
- Reset (reset_n low, async):
  - md_cnt=0, md_busy=0, stall_cnt=0.
  - Combinational outputs follow their inputs.
  - With all *_type=0 and D_md_use=0, every stall and fwd output is 0.
- Reset asserted mid-MD-operation clears md_cnt immediately; md_stall then depends only on E_md_start.
- No combinational path from stall outputs back into forwarding logic.

Test Plan:
- lw $8 in E (E_wb=8, E_type=3), D_rs=8, rs_tuse=1 -> stall_pc=stall_D=flush_E=1, stall_cause=01. Next cycle: M_type=3, M_wb=8 -> stall=0, and on the following cycle fwd_E_rs=3.
- Same register written by E ALU and M ALU, D_rs=9, rs_tuse=0 -> stall=1 (E ALU has Tnew 1). With rs_tuse=1 -> stall=0, fwd_D_rs=3 from the older M producer; once in E, fwd_E_rs=2.
- jal in E (E_type=1, E_wb=31), D_rs=31, rs_tuse=0 -> stall=0, fwd_D_rs=1. Same case with E_wb=0 -> fwd_D_rs=0.
- E_md_start=1, E_md_is_div=1, D_md_use=1 held -> stall for 11 cycles (start cycle + 10 busy), md_busy high exactly 10 cycles, stall_cause=10 throughout.
- Store in M (M_rt=4), W_wb=4, W_type=3 -> fwd_M_rt=1. With W_wb=0 -> fwd_M_rt=0.
- CNT_W=4, stall held 20 cycles -> stall_cnt=15 (saturated). cnt_clr pulsed alongside stall -> stall_cnt=0. reset_n pulsed low mid-div -> md_busy=0 asynchronously.

Source files
------------

// File: rtl/hazard_md_ctrl.sv
// Hazard unit for the 5-stage MIPS pipeline: Tnew/Tuse stall detection, D/E/M forwarding selects,
// a multiply/divide busy tracker that stalls HI/LO consumers, and a saturating stall-cycle counter.
module hazard_md_ctrl #(
  parameter int unsigned REG_AW      = 5,
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10,
  parameter int unsigned CNT_W       = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [REG_AW-1:0] D_rs,
  input  logic [REG_AW-1:0] D_rt,
  input  logic [1:0]        rs_tuse,
  input  logic [1:0]        rt_tuse,
  input  logic [REG_AW-1:0] E_rs,
  input  logic [REG_AW-1:0] E_rt,
  input  logic [REG_AW-1:0] M_rt,
  input  logic [REG_AW-1:0] E_wb,
  input  logic [REG_AW-1:0] M_wb,
  input  logic [REG_AW-1:0] W_wb,
  input  logic [1:0]        E_type,
  input  logic [1:0]        M_type,
  input  logic [1:0]        W_type,
  input  logic              E_md_start,
  input  logic              E_md_is_div,
  input  logic              D_md_use,
  input  logic              cnt_clr,
  output logic              stall_pc,
  output logic              stall_D,
  output logic              flush_E,
  output logic [1:0]        stall_cause,
  output logic [2:0]        fwd_D_rs,
  output logic [2:0]        fwd_D_rt,
  output logic [1:0]        fwd_E_rs,
  output logic [1:0]        fwd_E_rt,
  output logic              fwd_M_rt,
  output logic              md_busy,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam int unsigned MD_W = 8;
  localparam logic [1:0] T_NONE = 2'd0;
  localparam logic [1:0] T_PC   = 2'd1;
  localparam logic [1:0] T_ALU  = 2'd2;
  localparam logic [1:0] T_DM   = 2'd3;
  localparam logic [1:0] TUSE_NONE = 2'd3;

  // Cycles until a producer's result exists, counted from the stage it currently occupies.
  function automatic logic [1:0] tnew_e(input logic [1:0] t);
    case (t)
      T_ALU:   tnew_e = 2'd1;
      T_DM:    tnew_e = 2'd2;
      default: tnew_e = 2'd0;
    endcase
  endfunction

  function automatic logic [1:0] tnew_m(input logic [1:0] t);
    tnew_m = (t == T_DM) ? 2'd1 : 2'd0;
  endfunction

  function automatic logic hit(input logic [REG_AW-1:0] src, input logic [REG_AW-1:0] wb,
                               input logic [1:0] t);
    hit = (src == wb) && (wb != '0) && (t != T_NONE);
  endfunction

  function automatic logic need_stall(input logic [REG_AW-1:0] src, input logic [1:0] tuse,
                                      input logic [REG_AW-1:0] ewb, input logic [1:0] et,
                                      input logic [REG_AW-1:0] mwb, input logic [1:0] mt);
    need_stall = (tuse != TUSE_NONE) &&
                 ((hit(src, ewb, et) && (tnew_e(et) > tuse)) ||
                  (hit(src, mwb, mt) && (tnew_m(mt) > tuse)));
  endfunction

  // D-stage select: only ready producers are candidates, youngest first.
  function automatic logic [2:0] sel_d(input logic [REG_AW-1:0] src,
                                       input logic [REG_AW-1:0] ewb, input logic [1:0] et,
                                       input logic [REG_AW-1:0] mwb, input logic [1:0] mt,
                                       input logic [REG_AW-1:0] wwb, input logic [1:0] wt);
    if (hit(src, ewb, et) && et == T_PC)        sel_d = 3'd1;
    else if (hit(src, mwb, mt) && mt == T_PC)   sel_d = 3'd2;
    else if (hit(src, mwb, mt) && mt == T_ALU)  sel_d = 3'd3;
    else if (hit(src, wwb, wt))                 sel_d = 3'd4;
    else                                        sel_d = 3'd0;
  endfunction

  function automatic logic [1:0] sel_e(input logic [REG_AW-1:0] src,
                                       input logic [REG_AW-1:0] mwb, input logic [1:0] mt,
                                       input logic [REG_AW-1:0] wwb, input logic [1:0] wt);
    if (hit(src, mwb, mt) && mt == T_PC)        sel_e = 2'd1;
    else if (hit(src, mwb, mt) && mt == T_ALU)  sel_e = 2'd2;
    else if (hit(src, wwb, wt))                 sel_e = 2'd3;
    else                                        sel_e = 2'd0;
  endfunction

  logic [MD_W-1:0] md_cnt;
  logic            data_stall;
  logic            md_stall;
  logic            stall;

  always_comb begin
    data_stall = need_stall(D_rs, rs_tuse, E_wb, E_type, M_wb, M_type) ||
                 need_stall(D_rt, rt_tuse, E_wb, E_type, M_wb, M_type);
    md_stall   = D_md_use && (md_busy || E_md_start);
    stall      = data_stall || md_stall;
  end

  assign stall_pc    = stall;
  assign stall_D     = stall;
  assign flush_E     = stall;
  assign stall_cause = {md_stall, data_stall};

  // Forwarding depends only on pipeline contents, never on the stall decision.
  always_comb begin
    fwd_D_rs = sel_d(D_rs, E_wb, E_type, M_wb, M_type, W_wb, W_type);
    fwd_D_rt = sel_d(D_rt, E_wb, E_type, M_wb, M_type, W_wb, W_type);
    fwd_E_rs = sel_e(E_rs, M_wb, M_type, W_wb, W_type);
    fwd_E_rt = sel_e(E_rt, M_wb, M_type, W_wb, W_type);
    fwd_M_rt = hit(M_rt, W_wb, W_type);
  end

  // A new mult/div reloads the counter even while a previous one is still running.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      md_cnt <= '0;
    end else if (E_md_start) begin
      md_cnt <= E_md_is_div ? MD_W'(DIV_CYCLES) : MD_W'(MULT_CYCLES);
    end else if (md_cnt != '0) begin
      md_cnt <= md_cnt - MD_W'(1);
    end
  end

  assign md_busy = (md_cnt != '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt <= '0;
    end else if (cnt_clr) begin
      stall_cnt <= '0;
    end else if (stall && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_md_ctrl.sv
// Directed self-checking bench for hazard_md_ctrl (counter narrowed to 4 bits to reach saturation).
module tb_hazard_md_ctrl;

  localparam int unsigned REG_AW = 5;
  localparam int unsigned CNT_W  = 4;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [REG_AW-1:0] D_rs, D_rt, E_rs, E_rt, M_rt, E_wb, M_wb, W_wb;
  logic [1:0]        rs_tuse, rt_tuse, E_type, M_type, W_type;
  logic              E_md_start, E_md_is_div, D_md_use, cnt_clr;
  logic              stall_pc, stall_D, flush_E, fwd_M_rt, md_busy;
  logic [1:0]        stall_cause, fwd_E_rs, fwd_E_rt;
  logic [2:0]        fwd_D_rs, fwd_D_rt;
  logic [CNT_W-1:0]  stall_cnt;

  int checks = 0;
  int failures = 0;

  hazard_md_ctrl #(.REG_AW(REG_AW), .MULT_CYCLES(5), .DIV_CYCLES(10), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset_n(reset_n),
    .D_rs(D_rs), .D_rt(D_rt), .rs_tuse(rs_tuse), .rt_tuse(rt_tuse),
    .E_rs(E_rs), .E_rt(E_rt), .M_rt(M_rt),
    .E_wb(E_wb), .M_wb(M_wb), .W_wb(W_wb),
    .E_type(E_type), .M_type(M_type), .W_type(W_type),
    .E_md_start(E_md_start), .E_md_is_div(E_md_is_div), .D_md_use(D_md_use),
    .cnt_clr(cnt_clr),
    .stall_pc(stall_pc), .stall_D(stall_D), .flush_E(flush_E), .stall_cause(stall_cause),
    .fwd_D_rs(fwd_D_rs), .fwd_D_rt(fwd_D_rt), .fwd_E_rs(fwd_E_rs), .fwd_E_rt(fwd_E_rt),
    .fwd_M_rt(fwd_M_rt), .md_busy(md_busy), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic idle();
    D_rs = '0; D_rt = '0; E_rs = '0; E_rt = '0; M_rt = '0;
    E_wb = '0; M_wb = '0; W_wb = '0;
    rs_tuse = 2'd3; rt_tuse = 2'd3;
    E_type = 2'd0; M_type = 2'd0; W_type = 2'd0;
    E_md_start = 1'b0; E_md_is_div = 1'b0; D_md_use = 1'b0; cnt_clr = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  int busy_n;
  int stall_n;
  int cause_bad;

  initial begin
    reset_n = 1'b0;
    idle();
    #2;
    check("rst_stall", 32'(stall_pc | stall_D | flush_E), 32'd0);
    check("rst_cause", 32'(stall_cause), 32'd0);
    check("rst_fwd", 32'({fwd_D_rs, fwd_D_rt, fwd_E_rs, fwd_E_rt, fwd_M_rt}), 32'd0);
    check("rst_md_busy", 32'(md_busy), 32'd0);
    check("rst_cnt", 32'(stall_cnt), 32'd0);
    next_cycle();
    reset_n = 1'b1;

    // Load-use: lw $8 in E, consumer in D needs it in E
    next_cycle();
    E_wb = 5'd8; E_type = 2'd3; D_rs = 5'd8; rs_tuse = 2'd1;
    #1;
    check("lw_stall_pc", 32'(stall_pc), 32'd1);
    check("lw_stall_D", 32'(stall_D), 32'd1);
    check("lw_flush_E", 32'(flush_E), 32'd1);
    check("lw_cause", 32'(stall_cause), 32'd1);
    next_cycle();
    idle(); M_type = 2'd3; M_wb = 5'd8; D_rs = 5'd8; rs_tuse = 2'd1;
    #1;
    check("lw_m_nostall", 32'(stall_pc), 32'd0);
    check("lw_m_fwd_d", 32'(fwd_D_rs), 32'd0);
    next_cycle();
    idle(); E_rs = 5'd8; W_wb = 5'd8; W_type = 2'd3;
    #1;
    check("lw_fwd_E_rs", 32'(fwd_E_rs), 32'd3);

    // Two ALU producers of $9
    next_cycle();
    idle(); E_wb = 5'd9; E_type = 2'd2; M_wb = 5'd9; M_type = 2'd2; D_rs = 5'd9; rs_tuse = 2'd0;
    #1;
    check("alu_tuse0_stall", 32'(stall_pc), 32'd1);
    rs_tuse = 2'd1; D_rt = 5'd9; rt_tuse = 2'd1;
    #1;
    check("alu_tuse1_stall", 32'(stall_pc), 32'd0);
    check("alu_fwd_D_rs", 32'(fwd_D_rs), 32'd3);
    check("alu_fwd_D_rt", 32'(fwd_D_rt), 32'd3);
    next_cycle();
    idle(); E_rs = 5'd9; M_wb = 5'd9; M_type = 2'd2; W_wb = 5'd9; W_type = 2'd2;
    #1;
    check("alu_fwd_E_rs", 32'(fwd_E_rs), 32'd2);

    // Unused source never stalls; M link result forwarded to E rt
    next_cycle();
    idle(); E_wb = 5'd7; E_type = 2'd3; D_rs = 5'd7; rs_tuse = 2'd3;
    E_rt = 5'd31; M_wb = 5'd31; M_type = 2'd1;
    #1;
    check("tuse3_nostall", 32'(stall_pc), 32'd0);
    check("fwd_E_rt_mpc", 32'(fwd_E_rt), 32'd1);

    // jal in E feeding a jr in D; $0 never forwarded
    next_cycle();
    idle(); E_type = 2'd1; E_wb = 5'd31; D_rs = 5'd31; rs_tuse = 2'd0;
    #1;
    check("jal_stall", 32'(stall_pc), 32'd0);
    check("jal_fwd_D_rs", 32'(fwd_D_rs), 32'd1);
    E_wb = 5'd0; D_rs = 5'd0;
    #1;
    check("jal_r0_fwd", 32'(fwd_D_rs), 32'd0);

    // Store data forwarding in M
    next_cycle();
    idle(); M_rt = 5'd4; W_wb = 5'd4; W_type = 2'd3;
    #1;
    check("st_fwd_M_rt", 32'(fwd_M_rt), 32'd1);
    W_wb = 5'd0; M_rt = 5'd0;
    #1;
    check("st_r0_fwd_M_rt", 32'(fwd_M_rt), 32'd0);

    // Divide with a HI/LO consumer held in D
    next_cycle();
    idle(); E_md_start = 1'b1; E_md_is_div = 1'b1; D_md_use = 1'b1;
    #1;
    check("div_start_stall", 32'(stall_pc), 32'd1);
    check("div_start_cause", 32'(stall_cause), 32'd2);
    check("div_start_busy", 32'(md_busy), 32'd0);
    busy_n = 0; stall_n = 1; cause_bad = 0;
    for (int i = 0; i < 14; i++) begin
      next_cycle();
      E_md_start = 1'b0; E_md_is_div = 1'b0;
      #1;
      if (md_busy) busy_n++;
      if (stall_pc) begin
        stall_n++;
        if (stall_cause != 2'd2) cause_bad++;
      end
    end
    check("div_busy_cycles", 32'(busy_n), 32'd10);
    check("div_stall_cycles", 32'(stall_n), 32'd11);
    check("div_cause_const", 32'(cause_bad), 32'd0);

    // Multiply with no consumer: busy 5 cycles, no stall
    next_cycle();
    idle(); E_md_start = 1'b1;
    #1;
    check("mult_nouse_stall", 32'(stall_pc), 32'd0);
    busy_n = 0;
    for (int i = 0; i < 8; i++) begin
      next_cycle();
      E_md_start = 1'b0;
      #1;
      if (md_busy) busy_n++;
    end
    check("mult_busy_cycles", 32'(busy_n), 32'd5);

    // Stall counter: clear, saturate, clear wins over increment, then count again
    next_cycle();
    idle(); cnt_clr = 1'b1;
    next_cycle();
    cnt_clr = 1'b0;
    check("cnt_clr", 32'(stall_cnt), 32'd0);
    E_wb = 5'd3; E_type = 2'd3; D_rt = 5'd3; rt_tuse = 2'd0;
    repeat (20) next_cycle();
    check("cnt_sat", 32'(stall_cnt), 32'd15);
    cnt_clr = 1'b1;
    next_cycle();
    check("cnt_clr_prio", 32'(stall_cnt), 32'd0);
    cnt_clr = 1'b0;
    next_cycle();
    check("cnt_after_clr", 32'(stall_cnt), 32'd1);

    // Async reset in the middle of a divide
    idle(); E_md_start = 1'b1; E_md_is_div = 1'b1; D_md_use = 1'b1;
    next_cycle();
    E_md_start = 1'b0;
    repeat (3) next_cycle();
    check("mid_div_busy", 32'(md_busy), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check("rst_mid_div_busy", 32'(md_busy), 32'd0);
    check("rst_mid_div_stall", 32'(stall_pc), 32'd0);
    check("rst_mid_div_cnt", 32'(stall_cnt), 32'd0);
    E_md_start = 1'b1;
    #1;
    check("rst_start_stall", 32'(stall_cause), 32'd2);
    E_md_start = 1'b0;
    next_cycle();
    reset_n = 1'b1;
    next_cycle();
    check("post_rst_busy", 32'(md_busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
